// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner: FSM state encoding, matrix
// geometry, the column drive pattern used after reset, and a helper that
// picks the winning row when several keys in one column are held.
// No ports (package).

package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Column 0 driven low, all others released.
  localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Index of the lowest-numbered active-low row; row 0 wins a tie.
  // The loop runs downward so the last assignment is the smallest index.
  function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows);
    lowest_low_row = 2'd0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!rows[r]) lowest_low_row = 2'(r);
    end
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync
// Two-flop synchronizer for the four asynchronous matrix return lines.
// Resets to all-high so that no key appears pressed out of reset.
// Ports:
//   clk    in   1  system clock
//   rst_n  in   1  asynchronous active-low reset
//   d      in   4  raw row lines (asynchronous)
//   q      out  4  synchronized row lines

module keypad_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] stage1;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= 4'b1111;
      q      <= 4'b1111;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low key matrix one column at a time, debounces a press
// and its release, and reports one hex code (row*4 + col) per accepted key.
// Optional feature macro: KEYPAD_ACCUM_EN adds an 8-digit shift register of
// the accepted codes (entry_value) with a synchronous clear (entry_clr).
// Ports:
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   row_n        in   4   matrix return lines, active-low, asynchronous
//   col_n        out  4   column drive, one-hot active-low
//   key_code     out  4   last accepted key code
//   key_valid    out  1   one-cycle pulse when key_code updates
//   key_down     out  1   high while the accepted key is held
//   entry_clr    in   1   synchronous clear of entry_value (KEYPAD_ACCUM_EN)
//   entry_value  out  32  accumulated codes, newest in [3:0] (KEYPAD_ACCUM_EN)

module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 150_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down
`ifdef KEYPAD_ACCUM_EN
  ,
  input  logic        entry_clr,
  output logic [31:0] entry_value
`endif
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    col_idx;
  logic [3:0]    row_latch;
  logic [3:0]    rows_sync;
  logic          all_high;
  logic          accept;
  logic [3:0]    new_code;

  keypad_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (rows_sync)
  );

  assign all_high = &rows_sync;

  // The last of DEBOUNCE_CYCLES consecutive matching cycles accepts the key.
  assign accept   = (state == DEBOUNCE) && (rows_sync == row_latch) && (cnt == DEB_LAST);
  assign new_code = {lowest_low_row(row_latch), col_idx};

  // One counter serves both the column dwell and the debounce intervals,
  // since only one of them is ever running. It is cleared on every state
  // change and never counts past its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      cnt       <= '0;
      col_idx   <= 2'd0;
      col_n     <= COL_RESET;
      row_latch <= 4'b1111;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          // Rows are only looked at on the last dwell cycle so the
          // synchronizer has caught up with the newly driven column.
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (!all_high) begin
              row_latch <= rows_sync;
              state     <= DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
              col_n   <= {col_n[2:0], col_n[3]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (rows_sync != row_latch) begin
            state   <= SCAN;
            cnt     <= '0;
            col_idx <= col_idx + 2'd1;
            col_n   <= {col_n[2:0], col_n[3]};
          end else if (accept) begin
            key_code  <= new_code;
            key_valid <= 1'b1;
            key_down  <= 1'b1;
            state     <= PRESSED;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PRESSED: begin
          if (all_high) begin
            state <= RELEASE;
            cnt   <= '0;
          end
        end

        RELEASE: begin
          // A re-contact restarts the release debounce without re-reporting.
          if (!all_high) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            key_down <= 1'b0;
            state    <= SCAN;
            cnt      <= '0;
            col_idx  <= col_idx + 2'd1;
            col_n    <= {col_n[2:0], col_n[3]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEYPAD_ACCUM_EN
  // Shift each accepted code in at the bottom; a clear in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_value <= 32'd0;
    end else if (entry_clr) begin
      entry_value <= 32'd0;
    end else if (accept) begin
      entry_value <= {entry_value[27:0], new_code};
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// A behavioural key matrix pulls row r low whenever column c is driven and
// key (r,c) is held. Expected codes come from key coordinates (min row*4+col),
// and expected timing from sync latency, dwell and debounce lengths.
// Compile with +define+KEYPAD_ACCUM_EN to also exercise the accumulator.

module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int SYNC_LAT = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
`ifdef KEYPAD_ACCUM_EN
  logic        entry_clr = 1'b0;
  logic [31:0] entry_value;
`endif

  logic [15:0] pressed = 16'd0;

  int          checks      = 0;
  int          errors      = 0;
  int          valid_count = 0;
  logic [3:0]  prev_code   = 4'd0;
  logic        prev_valid  = 1'b0;

  always #5 clk = ~clk;

  // Key matrix: bit r*4+c of pressed is key (r,c).
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (col_n[c] == 1'b0 && pressed[r*4+c]) row_n[r] = 1'b0;
      end
    end
  end

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_down   (key_down)
`ifdef KEYPAD_ACCUM_EN
    ,
    .entry_clr  (entry_clr),
    .entry_value(entry_value)
`endif
  );

  // Continuous watch: key_valid is a single-cycle pulse, and key_code never
  // moves without it.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_code  = key_code;
      prev_valid = 1'b0;
    end else begin
      checks++;
      if (key_valid) begin
        valid_count++;
        if (prev_valid) begin
          errors++;
          $display("[TB] FAIL valid_width: key_valid high 2 consecutive cycles, required 1");
        end
      end else if (key_code !== prev_code) begin
        errors++;
        $display("[TB] FAIL code_hold: key_code=%0d without key_valid, required %0d", key_code, prev_code);
      end
      prev_code  = key_code;
      prev_valid = key_valid;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] target, input int budget, input string name);
    int n = 0;
    while (col_n !== target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (col_n !== target) begin
      errors++;
      $display("[TB] FAIL %s: col_n=%b required %b within %0d cycles", name, col_n, target, budget);
    end
  endtask

  task automatic wait_valid(input int budget, input string name, output bit ok);
    int start = valid_count;
    int n = 0;
    while (valid_count == start && n < budget) begin
      tick();
      n++;
    end
    ok = (valid_count != start);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: no key_valid within %0d cycles, required one", name, budget);
    end
  endtask

  task automatic wait_key_up(input int budget, input string name, output int n);
    n = 0;
    while (key_down === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (key_down !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: key_down=%b after %0d cycles, required 0", name, key_down, budget);
    end
  endtask

  // Press a set of keys, wait for the report, release and wait for key_down to drop.
  task automatic do_keystroke(input logic [15:0] mask, input int hold, output logic [3:0] code);
    bit ok;
    int n;
    pressed = mask;
    wait_valid(80, "keystroke_valid", ok);
    code = ok ? key_code : 4'hx;
    repeat (hold) tick();
    pressed = 16'd0;
    wait_key_up(60, "keystroke_release", n);
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    tick();
    tick();
    checks++;
    if (col_n !== 4'b1110) begin errors++; $display("[TB] FAIL reset_col: col_n=%b required 1110", col_n); end
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: key_valid=%b required 0", key_valid); end
    checks++;
    if (key_down !== 1'b0) begin errors++; $display("[TB] FAIL reset_down: key_down=%b required 0", key_down); end
    checks++;
    if (key_code !== 4'd0) begin errors++; $display("[TB] FAIL reset_code: key_code=%0d required 0", key_code); end
`ifdef KEYPAD_ACCUM_EN
    checks++;
    if (entry_value !== 32'd0) begin errors++; $display("[TB] FAIL reset_entry: entry_value=%h required 0", entry_value); end
`endif
    rst_n = 1'b1;
    // Each column is held for SCAN_DIV cycles, in order 0,1,2,3.
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      exp = ~(4'b0001 << ((i / SCAN_DIV) % 4));
      checks++;
      if (col_n !== exp) begin
        errors++;
        $display("[TB] FAIL rotate: cycle %0d col_n=%b required %b", i, col_n, exp);
      end
      tick();
    end
  endtask

  task automatic test_clean_press();
    int start = valid_count;
    int n = 0;
    int t_col = -1;
    wait_col(4'b1110, 40, "press_align");
    pressed[2*4+1] = 1'b1;
    while (valid_count == start && n < 60) begin
      tick();
      n++;
      if (t_col < 0 && col_n === 4'b1101) t_col = n;
    end
    checks++;
    if (valid_count == start) begin
      errors++;
      $display("[TB] FAIL press_valid: no key_valid within 60 cycles, required one");
    end
    // Column becomes active, its last dwell cycle detects, then DEB matches.
    checks++;
    if (n - t_col != SCAN_DIV + DEB) begin
      errors++;
      $display("[TB] FAIL press_latency: %0d cycles from column to key_valid, required %0d", n - t_col, SCAN_DIV + DEB);
    end
    checks++;
    if (key_code !== 4'd9) begin errors++; $display("[TB] FAIL press_code: key_code=%0d required 9", key_code); end
    checks++;
    if (key_down !== 1'b1) begin errors++; $display("[TB] FAIL press_down: key_down=%b required 1", key_down); end
    repeat (40) tick();
    checks++;
    if (col_n !== 4'b1101) begin errors++; $display("[TB] FAIL press_freeze: col_n=%b required 1101", col_n); end
    checks++;
    if (valid_count - start != 1) begin
      errors++;
      $display("[TB] FAIL press_count: %0d key_valid pulses, required 1", valid_count - start);
    end
  endtask

  task automatic test_release();
    int start = valid_count;
    int n;
    pressed[2*4+1] = 1'b0;
    repeat (3) tick();
    pressed[2*4+1] = 1'b1;
    repeat (2) tick();
    pressed[2*4+1] = 1'b0;
    wait_key_up(40, "release_down", n);
    // Synchronizer, one cycle to see all rows high, then DEB stable cycles.
    checks++;
    if (n != SYNC_LAT + 1 + DEB) begin
      errors++;
      $display("[TB] FAIL release_latency: key_down dropped after %0d cycles, required %0d", n, SYNC_LAT + 1 + DEB);
    end
    checks++;
    if (col_n !== 4'b1011) begin errors++; $display("[TB] FAIL release_col: col_n=%b required 1011", col_n); end
    checks++;
    if (valid_count != start) begin
      errors++;
      $display("[TB] FAIL release_novalid: %0d key_valid pulses, required 0", valid_count - start);
    end
  endtask

  task automatic test_bounce();
    int start = valid_count;
    bit ok;
    int n;
    pressed[0*4+3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (3) tick();
      pressed[0*4+3] = ~pressed[0*4+3];
    end
    checks++;
    if (valid_count != start) begin
      errors++;
      $display("[TB] FAIL bounce_quiet: %0d key_valid during bounce, required 0", valid_count - start);
    end
    pressed[0*4+3] = 1'b1;
    wait_valid(80, "bounce_valid", ok);
    checks++;
    if (key_code !== 4'd3) begin errors++; $display("[TB] FAIL bounce_code: key_code=%0d required 3", key_code); end
    repeat (30) tick();
    checks++;
    if (valid_count - start != 1) begin
      errors++;
      $display("[TB] FAIL bounce_count: %0d key_valid pulses, required 1", valid_count - start);
    end
    pressed = 16'd0;
    wait_key_up(60, "bounce_release", n);
  endtask

  task automatic test_two_keys();
    int start = valid_count;
    bit ok;
    int n;
    pressed = 16'd0;
    pressed[1*4+0] = 1'b1;
    pressed[3*4+0] = 1'b1;
    wait_valid(80, "two_valid", ok);
    checks++;
    if (key_code !== 4'd4) begin errors++; $display("[TB] FAIL two_code: key_code=%0d required 4", key_code); end
    repeat (20) tick();
    checks++;
    if (valid_count - start != 1) begin
      errors++;
      $display("[TB] FAIL two_count: %0d key_valid pulses, required 1", valid_count - start);
    end
    pressed = 16'd0;
    wait_key_up(60, "two_release", n);
  endtask

  task automatic test_random();
    int col, r1, r2, lo;
    logic [15:0] mask;
    logic [3:0]  exp, got;
    for (int i = 0; i < 8; i++) begin
      col  = int'($urandom_range(3, 0));
      r1   = int'($urandom_range(3, 0));
      r2   = int'($urandom_range(3, 0));
      mask = (16'd1 << (r1 * 4 + col)) | (16'd1 << (r2 * 4 + col));
      lo   = (r1 < r2) ? r1 : r2;
      exp  = 4'(lo * 4 + col);
      do_keystroke(mask, int'($urandom_range(10, 0)), got);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL random_code: rows %0d/%0d col %0d key_code=%0d required %0d", r1, r2, col, got, exp);
      end
    end
  endtask

`ifdef KEYPAD_ACCUM_EN
  task automatic test_accum();
    logic [31:0] model;
    logic [3:0]  got;
    int          k;
    entry_clr = 1'b1;
    tick();
    entry_clr = 1'b0;
    checks++;
    if (entry_value !== 32'd0) begin errors++; $display("[TB] FAIL accum_clr0: entry_value=%h required 0", entry_value); end
    for (int i = 1; i <= 3; i++) do_keystroke(16'd1 << i, 2, got);
    checks++;
    if (entry_value !== 32'h0000_0123) begin
      errors++;
      $display("[TB] FAIL accum_123: entry_value=%h required 00000123", entry_value);
    end
    entry_clr = 1'b1;
    tick();
    entry_clr = 1'b0;
    checks++;
    if (entry_value !== 32'd0) begin errors++; $display("[TB] FAIL accum_clr: entry_value=%h required 0", entry_value); end
    model = 32'd0;
    for (int i = 0; i < 9; i++) begin
      k = int'($urandom_range(15, 0));
      do_keystroke(16'd1 << k, 1, got);
      model = (model << 4) | 32'(k);
    end
    checks++;
    if (entry_value !== model) begin
      errors++;
      $display("[TB] FAIL accum_nine: entry_value=%h required %h", entry_value, model);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int start;
    wait_col(4'b1110, 40, "mid_align0");
    pressed = 16'd0;
    pressed[1*4+2] = 1'b1;
    wait_col(4'b1011, 40, "mid_align2");
    // Detection happens SCAN_DIV cycles in; stop partway through the debounce.
    repeat (SCAN_DIV + 2) tick();
    checks++;
    if (key_down !== 1'b0) begin errors++; $display("[TB] FAIL mid_predown: key_down=%b required 0", key_down); end
    start = valid_count;
    rst_n = 1'b0;
    #1;
    checks++;
    if (col_n !== 4'b1110) begin errors++; $display("[TB] FAIL mid_col: col_n=%b required 1110", col_n); end
    checks++;
    if (key_code !== 4'd0) begin errors++; $display("[TB] FAIL mid_code: key_code=%0d required 0", key_code); end
    checks++;
    if (key_valid !== 1'b0 || key_down !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_flags: key_valid=%b key_down=%b required 0 0", key_valid, key_down);
    end
`ifdef KEYPAD_ACCUM_EN
    checks++;
    if (entry_value !== 32'd0) begin errors++; $display("[TB] FAIL mid_entry: entry_value=%h required 0", entry_value); end
`endif
    pressed = 16'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    checks++;
    if (valid_count != start) begin
      errors++;
      $display("[TB] FAIL mid_novalid: %0d key_valid pulses, required 0", valid_count - start);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_two_keys();
    test_random();
`ifdef KEYPAD_ACCUM_EN
    test_accum();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
